// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the accumulator processor.
// Drives ALU op/operand selects and all datapath write strobes, one state per cycle.
module multicycle_control (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [4:0] Opcode,
  input  logic       MemReady,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       AccWrite,
  output logic [1:0] AccSrc,
  output logic       SPWrite,
  output logic       RAWrite,
  output logic       Illegal,
  output logic       Halted,
  output logic [3:0] State
);

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_FETCH   = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE  = 4'd1;
  localparam logic [STATE_W-1:0] S_EXEC_R  = 4'd2;
  localparam logic [STATE_W-1:0] S_EXEC_I  = 4'd3;
  localparam logic [STATE_W-1:0] S_ALU_WB  = 4'd4;
  localparam logic [STATE_W-1:0] S_BRANCH  = 4'd5;
  localparam logic [STATE_W-1:0] S_JAL     = 4'd6;
  localparam logic [STATE_W-1:0] S_SP_ADDR = 4'd7;
  localparam logic [STATE_W-1:0] S_MEM_RD  = 4'd8;
  localparam logic [STATE_W-1:0] S_MEM_WB  = 4'd9;
  localparam logic [STATE_W-1:0] S_MEM_WR  = 4'd10;
  localparam logic [STATE_W-1:0] S_SP_WB   = 4'd11;
  localparam logic [STATE_W-1:0] S_INPUT   = 4'd12;
  localparam logic [STATE_W-1:0] S_HALT    = 4'd13;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= S_FETCH;
    else       state <= state_next;
  end

  assign State = state;

  // Outputs are gated by Reset so strobes drop asynchronously, not at the next edge.
  always_comb begin
    state_next  = S_FETCH;
    ALUOp       = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    AccWrite    = 1'b0;
    AccSrc      = 2'b00;
    SPWrite     = 1'b0;
    RAWrite     = 1'b0;
    Illegal     = 1'b0;
    Halted      = 1'b0;
    if (!Reset) begin
      case (state)
        S_FETCH: begin
          MemRead    = 1'b1;
          ALUSrcB    = 2'b01;
          IRWrite    = MemReady;
          PCWrite    = MemReady;
          state_next = MemReady ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (Opcode)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd15, 5'd29:
              state_next = S_EXEC_R;
            5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14:
              state_next = S_EXEC_I;
            5'd16, 5'd17, 5'd18, 5'd19:
              state_next = S_BRANCH;
            5'd20:                state_next = S_JAL;
            5'd23, 5'd24, 5'd25:  state_next = S_SP_ADDR;
            5'd26:                state_next = S_INPUT;
            5'd31:                state_next = S_HALT;
            default: begin
              Illegal    = 1'b1;
              state_next = S_FETCH;
            end
          endcase
        end
        S_EXEC_R: begin
          ALUSrcA    = 2'b01;
          ALUOp      = 2'b10;
          state_next = S_ALU_WB;
        end
        S_EXEC_I: begin
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b10;
          ALUOp      = 2'b10;
          state_next = S_ALU_WB;
        end
        S_ALU_WB: AccWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA     = 2'b01;
          ALUOp       = 2'b10;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JAL: begin
          RAWrite  = 1'b1;
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_SP_ADDR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b10;
          case (Opcode)
            5'd23:   state_next = S_MEM_WR;
            5'd24:   state_next = S_MEM_RD;
            5'd25:   state_next = S_SP_WB;
            default: state_next = S_FETCH;
          endcase
        end
        S_MEM_RD: begin
          MemRead    = 1'b1;
          IorD       = 1'b1;
          state_next = MemReady ? S_MEM_WB : S_MEM_RD;
        end
        S_MEM_WB: begin
          AccWrite = 1'b1;
          AccSrc   = 2'b01;
        end
        S_MEM_WR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          state_next = MemReady ? S_FETCH : S_MEM_WR;
        end
        S_SP_WB: SPWrite = 1'b1;
        S_INPUT: begin
          AccWrite = 1'b1;
          AccSrc   = 2'b10;
        end
        S_HALT: begin
          Halted     = 1'b1;
          state_next = S_HALT;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule
